// File: rtl/image_proc_sequencer_if.sv
// Bus bundle between the sequencer and its neighbours: the frame-memory
// read/write ports and the cell processor's extPorts side.
//   master : sequencer side (drives strobes, addresses, processor operands)
//   slave  : memory/processor side (drives read data and processedPixel)
interface image_proc_sequencer_if #(
  parameter int unsigned PIXEL_DEPTH  = 8,
  parameter int unsigned OPCODE_WIDTH = 4,
  parameter int unsigned ADDR_WIDTH   = 16
);
  logic                    rd_en;
  logic [ADDR_WIDTH-1:0]   rd_addr_a;
  logic [ADDR_WIDTH-1:0]   rd_addr_b;
  logic [PIXEL_DEPTH-1:0]  rd_data_a;
  logic [PIXEL_DEPTH-1:0]  rd_data_b;
  logic                    wr_en;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [PIXEL_DEPTH-1:0]  wr_data;
  logic [PIXEL_DEPTH-1:0]  pixelA;
  logic [PIXEL_DEPTH-1:0]  pixelB;
  logic [PIXEL_DEPTH-1:0]  userInputA;
  logic [OPCODE_WIDTH-1:0] opcode;
  logic [PIXEL_DEPTH-1:0]  processedPixel;

  modport master (
    output rd_en, rd_addr_a, rd_addr_b,
    input  rd_data_a, rd_data_b,
    output wr_en, wr_addr, wr_data,
    output pixelA, pixelB, userInputA, opcode,
    input  processedPixel
  );

  modport slave (
    input  rd_en, rd_addr_a, rd_addr_b,
    output rd_data_a, rd_data_b,
    input  wr_en, wr_addr, wr_data,
    input  pixelA, pixelB, userInputA, opcode,
    output processedPixel
  );
endinterface

// File: rtl/image_proc_sequencer.sv
// Sequences the cell processor over a block of pixels. A start latches the run
// configuration; each index then reads pixelA/pixelB from two source regions,
// presents them to the processor, and writes processedPixel to the destination.
// Ports:
//   clk, rst           clock; asynchronous active-low reset
//   i_start, i_abort   run control (start sampled only in idle)
//   i_cfg_*            run configuration, latched on start
//   o_busy, o_done     high outside idle; one-cycle completion pulse
//   bus (master)       frame-memory read/write ports and processor operands
// All outputs are registered.
module image_proc_sequencer #(
  parameter int unsigned PIXEL_DEPTH  = 8,
  parameter int unsigned OPCODE_WIDTH = 4,
  parameter int unsigned ADDR_WIDTH   = 16,
  parameter int unsigned PROC_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_start,
  input  logic                    i_abort,
  input  logic [OPCODE_WIDTH-1:0] i_cfg_opcode,
  input  logic [PIXEL_DEPTH-1:0]  i_cfg_user,
  input  logic [ADDR_WIDTH-1:0]   i_cfg_num_pixels,
  input  logic [ADDR_WIDTH-1:0]   i_cfg_src_a_base,
  input  logic [ADDR_WIDTH-1:0]   i_cfg_src_b_base,
  input  logic [ADDR_WIDTH-1:0]   i_cfg_dst_base,
  output logic                    o_busy,
  output logic                    o_done,
  image_proc_sequencer_if.master  bus
);

  localparam int unsigned CntW = (PROC_LATENCY > 1) ? $clog2(PROC_LATENCY) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StLoad,
    StProc,
    StWrite,
    StDone
  } state_e;

  state_e                  r_state;
  logic [ADDR_WIDTH-1:0]   r_idx;
  logic [CntW-1:0]         r_proc_cnt;
  logic [ADDR_WIDTH-1:0]   r_num;
  logic [ADDR_WIDTH-1:0]   r_src_a;
  logic [ADDR_WIDTH-1:0]   r_src_b;
  logic [ADDR_WIDTH-1:0]   r_dst;

  logic                    r_rd_en;
  logic [ADDR_WIDTH-1:0]   r_rd_addr_a;
  logic [ADDR_WIDTH-1:0]   r_rd_addr_b;
  logic                    r_wr_en;
  logic [ADDR_WIDTH-1:0]   r_wr_addr;
  logic [PIXEL_DEPTH-1:0]  r_wr_data;
  logic [PIXEL_DEPTH-1:0]  r_pixel_a;
  logic [PIXEL_DEPTH-1:0]  r_pixel_b;
  logic [PIXEL_DEPTH-1:0]  r_user;
  logic [OPCODE_WIDTH-1:0] r_opcode;
  logic                    r_busy;
  logic                    r_done;

  logic [ADDR_WIDTH-1:0]   w_idx_next;
  logic [ADDR_WIDTH-1:0]   w_num_m1;
  logic                    w_last;

  assign w_idx_next = r_idx + 1'b1;
  assign w_num_m1   = r_num - 1'b1;
  assign w_last     = (r_idx == w_num_m1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= StIdle;
      r_idx       <= '0;
      r_proc_cnt  <= '0;
      r_num       <= '0;
      r_src_a     <= '0;
      r_src_b     <= '0;
      r_dst       <= '0;
      r_rd_en     <= 1'b0;
      r_rd_addr_a <= '0;
      r_rd_addr_b <= '0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_pixel_a   <= '0;
      r_pixel_b   <= '0;
      r_user      <= '0;
      r_opcode    <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      // Strobes are single-cycle pulses; each state that needs one re-asserts it.
      r_rd_en <= 1'b0;
      r_wr_en <= 1'b0;
      r_done  <= 1'b0;
      if ((r_state != StIdle) && i_abort) begin
        // Abort beats every in-run transition, so no write or done can follow.
        r_state <= StIdle;
        r_busy  <= 1'b0;
      end else begin
        unique case (r_state)
          StIdle: begin
            if (i_start) begin
              r_num    <= i_cfg_num_pixels;
              r_src_a  <= i_cfg_src_a_base;
              r_src_b  <= i_cfg_src_b_base;
              r_dst    <= i_cfg_dst_base;
              r_opcode <= i_cfg_opcode;
              r_user   <= i_cfg_user;
              r_idx    <= '0;
              r_busy   <= 1'b1;
              if (i_cfg_num_pixels == '0) begin
                r_state <= StDone;
                r_done  <= 1'b1;
              end else begin
                r_state     <= StRead;
                r_rd_en     <= 1'b1;
                r_rd_addr_a <= i_cfg_src_a_base;
                r_rd_addr_b <= i_cfg_src_b_base;
              end
            end
          end
          StRead: begin
            r_state <= StLoad;
          end
          StLoad: begin
            r_pixel_a  <= bus.rd_data_a;
            r_pixel_b  <= bus.rd_data_b;
            r_proc_cnt <= CntW'(PROC_LATENCY - 1);
            r_state    <= StProc;
          end
          StProc: begin
            if (r_proc_cnt == '0) begin
              r_state   <= StWrite;
              r_wr_en   <= 1'b1;
              r_wr_addr <= r_dst + r_idx;
              r_wr_data <= bus.processedPixel;
            end else begin
              r_proc_cnt <= r_proc_cnt - 1'b1;
            end
          end
          StWrite: begin
            if (w_last) begin
              r_state <= StDone;
              r_done  <= 1'b1;
            end else begin
              r_idx       <= w_idx_next;
              r_state     <= StRead;
              r_rd_en     <= 1'b1;
              r_rd_addr_a <= r_src_a + w_idx_next;
              r_rd_addr_b <= r_src_b + w_idx_next;
            end
          end
          StDone: begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.rd_en      = r_rd_en;
  assign bus.rd_addr_a  = r_rd_addr_a;
  assign bus.rd_addr_b  = r_rd_addr_b;
  assign bus.wr_en      = r_wr_en;
  assign bus.wr_addr    = r_wr_addr;
  assign bus.wr_data    = r_wr_data;
  assign bus.pixelA     = r_pixel_a;
  assign bus.pixelB     = r_pixel_b;
  assign bus.userInputA = r_user;
  assign bus.opcode     = r_opcode;
  assign o_busy         = r_busy;
  assign o_done         = r_done;

endmodule

// File: tb/tb_image_proc_sequencer.sv
module tb_image_proc_sequencer;

  logic        clk;
  logic        rst;
  logic        i_start;
  logic        i_abort;
  logic [3:0]  i_cfg_opcode;
  logic [7:0]  i_cfg_user;
  logic [15:0] i_cfg_num_pixels;
  logic [15:0] i_cfg_src_a_base;
  logic [15:0] i_cfg_src_b_base;
  logic [15:0] i_cfg_dst_base;
  logic        busy1, done1, busy2, done2;

  int checks = 0;
  int errors = 0;

  image_proc_sequencer_if #(.PIXEL_DEPTH(8), .OPCODE_WIDTH(4), .ADDR_WIDTH(16)) bus1 ();
  image_proc_sequencer_if #(.PIXEL_DEPTH(8), .OPCODE_WIDTH(4), .ADDR_WIDTH(16)) bus2 ();

  image_proc_sequencer #(.PIXEL_DEPTH(8), .OPCODE_WIDTH(4), .ADDR_WIDTH(16),
                         .PROC_LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst), .i_start(i_start), .i_abort(i_abort),
    .i_cfg_opcode(i_cfg_opcode), .i_cfg_user(i_cfg_user),
    .i_cfg_num_pixels(i_cfg_num_pixels), .i_cfg_src_a_base(i_cfg_src_a_base),
    .i_cfg_src_b_base(i_cfg_src_b_base), .i_cfg_dst_base(i_cfg_dst_base),
    .o_busy(busy1), .o_done(done1), .bus(bus1)
  );

  // Longer processor latency, needed for a run with more than one PROC cycle.
  image_proc_sequencer #(.PIXEL_DEPTH(8), .OPCODE_WIDTH(4), .ADDR_WIDTH(16),
                         .PROC_LATENCY(2)) u_dut2 (
    .clk(clk), .rst(rst), .i_start(i_start), .i_abort(i_abort),
    .i_cfg_opcode(i_cfg_opcode), .i_cfg_user(i_cfg_user),
    .i_cfg_num_pixels(i_cfg_num_pixels), .i_cfg_src_a_base(i_cfg_src_a_base),
    .i_cfg_src_b_base(i_cfg_src_b_base), .i_cfg_dst_base(i_cfg_dst_base),
    .o_busy(busy2), .o_done(done2), .bus(bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] mem_a(input logic [15:0] addr);
    return addr[7:0] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] mem_b(input logic [15:0] addr);
    return addr[7:0] + 8'h11;
  endfunction

  function automatic logic [7:0] proc(input logic [7:0] a, input logic [7:0] b,
                                      input logic [7:0] u, input logic [3:0] op);
    return (a + b + u) ^ {4'h0, op};
  endfunction

  // Frame memory: read data valid the cycle after rd_en.
  always @(posedge clk) begin
    if (bus1.rd_en) begin
      bus1.rd_data_a <= mem_a(bus1.rd_addr_a);
      bus1.rd_data_b <= mem_b(bus1.rd_addr_b);
    end
    if (bus2.rd_en) begin
      bus2.rd_data_a <= mem_a(bus2.rd_addr_a);
      bus2.rd_data_b <= mem_b(bus2.rd_addr_b);
    end
  end

  assign bus1.processedPixel = proc(bus1.pixelA, bus1.pixelB, bus1.userInputA, bus1.opcode);
  assign bus2.processedPixel = proc(bus2.pixelA, bus2.pixelB, bus2.userInputA, bus2.opcode);

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input logic [3:0] op, input logic [7:0] u, input logic [15:0] n,
                         input logic [15:0] sa, input logic [15:0] sb, input logic [15:0] d);
    i_cfg_opcode     = op;
    i_cfg_user       = u;
    i_cfg_num_pixels = n;
    i_cfg_src_a_base = sa;
    i_cfg_src_b_base = sb;
    i_cfg_dst_base   = d;
  endtask

  // Pulse start for one cycle; returns at the sample point of cycle T+1.
  task automatic start_run();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic settle();
    for (int i = 0; i < 24; i++) tick();
  endtask

  task automatic test_reset();
    checks++;
    if ({bus1.rd_en, bus1.wr_en, busy1, done1} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_strobes got %b want 0000", {bus1.rd_en, bus1.wr_en, busy1, done1});
    end
    checks++;
    if ({bus1.rd_addr_a, bus1.rd_addr_b, bus1.wr_addr} !== 48'h0) begin
      errors++;
      $display("FAIL reset_addrs got %h want 0",
               {bus1.rd_addr_a, bus1.rd_addr_b, bus1.wr_addr});
    end
    checks++;
    if ({bus1.wr_data, bus1.pixelA, bus1.pixelB, bus1.userInputA, bus1.opcode} !== 36'h0) begin
      errors++;
      $display("FAIL reset_data got %h want 0",
               {bus1.wr_data, bus1.pixelA, bus1.pixelB, bus1.userInputA, bus1.opcode});
    end
  endtask

  // N=3, srcA=0x10, srcB=0x20, dst=0x30, user=0x05, opcode=3.
  task automatic test_basic();
    logic [7:0] exp_data [3];
    exp_data[0] = 8'h83;
    exp_data[1] = 8'h81;
    exp_data[2] = 8'h83;
    set_cfg(4'h3, 8'h05, 16'd3, 16'h0010, 16'h0020, 16'h0030);
    start_run();
    for (int c = 1; c <= 14; c++) begin
      logic exp_rd, exp_wr, exp_busy, exp_done;
      exp_rd   = (c == 1) || (c == 5) || (c == 9);
      exp_wr   = (c == 4) || (c == 8) || (c == 12);
      exp_busy = (c <= 13);
      exp_done = (c == 13);
      checks++;
      if ({bus1.rd_en, bus1.wr_en, busy1, done1} !== {exp_rd, exp_wr, exp_busy, exp_done}) begin
        errors++;
        $display("FAIL basic_ctrl c=%0d got %b want %b", c,
                 {bus1.rd_en, bus1.wr_en, busy1, done1}, {exp_rd, exp_wr, exp_busy, exp_done});
      end
      if (exp_rd) begin
        checks++;
        if (bus1.rd_addr_a !== 16'h0010 + 16'((c - 1) / 4) ||
            bus1.rd_addr_b !== 16'h0020 + 16'((c - 1) / 4)) begin
          errors++;
          $display("FAIL basic_rd_addr c=%0d got %h/%h", c, bus1.rd_addr_a, bus1.rd_addr_b);
        end
      end
      if (exp_wr) begin
        checks++;
        if (bus1.wr_addr !== 16'h0030 + 16'(c / 4 - 1) || bus1.wr_data !== exp_data[c / 4 - 1]) begin
          errors++;
          $display("FAIL basic_wr c=%0d got %h:%h want %h:%h", c, bus1.wr_addr, bus1.wr_data,
                   16'h0030 + 16'(c / 4 - 1), exp_data[c / 4 - 1]);
        end
      end
      if (c == 1) begin
        checks++;
        if (bus1.opcode !== 4'h3 || bus1.userInputA !== 8'h05) begin
          errors++;
          $display("FAIL basic_op got %h/%h want 3/05", bus1.opcode, bus1.userInputA);
        end
      end
      if (c == 3 || c == 14) begin
        // Pixel 0 in PROC, and last pixel held afterwards in idle.
        checks++;
        if (bus1.pixelA !== ((c == 3) ? 8'h4A : 8'h48) ||
            bus1.pixelB !== ((c == 3) ? 8'h31 : 8'h33)) begin
          errors++;
          $display("FAIL basic_pixels c=%0d got %h/%h", c, bus1.pixelA, bus1.pixelB);
        end
      end
      tick();
    end
    settle();
  endtask

  task automatic test_zero();
    set_cfg(4'h1, 8'h22, 16'd0, 16'h0100, 16'h0200, 16'h0300);
    start_run();
    for (int c = 1; c <= 4; c++) begin
      checks++;
      if ({bus1.rd_en, bus1.wr_en, busy1, done1} !== {1'b0, 1'b0, c == 1, c == 1}) begin
        errors++;
        $display("FAIL zero_ctrl c=%0d got %b want %b", c,
                 {bus1.rd_en, bus1.wr_en, busy1, done1}, {1'b0, 1'b0, c == 1, c == 1});
      end
      tick();
    end
    settle();
  endtask

  task automatic test_wrap();
    set_cfg(4'h2, 8'h10, 16'd2, 16'hFFFF, 16'h0000, 16'hFFFF);
    start_run();
    for (int c = 1; c <= 9; c++) begin
      if (c == 1 || c == 5) begin
        checks++;
        if (bus1.rd_en !== 1'b1 || bus1.rd_addr_a !== ((c == 1) ? 16'hFFFF : 16'h0000)) begin
          errors++;
          $display("FAIL wrap_rd_addr c=%0d got %b:%h", c, bus1.rd_en, bus1.rd_addr_a);
        end
      end
      if (c == 4 || c == 8) begin
        checks++;
        if (bus1.wr_en !== 1'b1 || bus1.wr_addr !== ((c == 4) ? 16'hFFFF : 16'h0000) ||
            bus1.wr_data !== ((c == 4) ? proc(8'hA5, 8'h11, 8'h10, 4'h2)
                                       : proc(8'h5A, 8'h12, 8'h10, 4'h2))) begin
          errors++;
          $display("FAIL wrap_wr c=%0d got %b:%h:%h", c, bus1.wr_en, bus1.wr_addr, bus1.wr_data);
        end
      end
      if (c == 9) begin
        checks++;
        if (done1 !== 1'b1) begin
          errors++;
          $display("FAIL wrap_done got %b want 1", done1);
        end
      end
      tick();
    end
    settle();
  endtask

  // Uses the PROC_LATENCY=2 instance: 5 cycles per pixel, pixel 1 PROC at c=8,9.
  task automatic test_abort();
    int wr_count = 0;
    int done_count = 0;
    set_cfg(4'h3, 8'h05, 16'd3, 16'h0010, 16'h0020, 16'h0030);
    start_run();
    for (int c = 1; c <= 14; c++) begin
      if (bus2.wr_en) wr_count++;
      if (done2) done_count++;
      if (c == 5) begin
        checks++;
        if (bus2.wr_en !== 1'b1 || bus2.wr_addr !== 16'h0030 || bus2.wr_data !== 8'h83) begin
          errors++;
          $display("FAIL abort_first_wr got %b:%h:%h want 1:0030:83",
                   bus2.wr_en, bus2.wr_addr, bus2.wr_data);
        end
      end
      if (c == 10) begin
        checks++;
        if (busy2 !== 1'b0) begin
          errors++;
          $display("FAIL abort_idle got busy=%b want 0", busy2);
        end
      end
      i_abort = (c == 9);
      tick();
    end
    i_abort = 1'b0;
    checks++;
    if (wr_count != 1 || done_count != 0) begin
      errors++;
      $display("FAIL abort_counts got wr=%0d done=%0d want wr=1 done=0", wr_count, done_count);
    end
    settle();
  endtask

  task automatic test_reset_mid_run();
    set_cfg(4'h3, 8'h05, 16'd3, 16'h0010, 16'h0020, 16'h0030);
    start_run();
    for (int c = 1; c < 4; c++) tick();
    // c=4: WRITE of pixel 0 on instance 1.
    rst = 1'b0;
    #1;
    checks++;
    if ({bus1.rd_en, bus1.wr_en, busy1, done1, bus1.wr_addr, bus1.wr_data,
         bus1.pixelA, bus1.pixelB, bus1.userInputA, bus1.opcode, bus1.rd_addr_a} !== 72'h0) begin
      errors++;
      $display("FAIL rst_mid_run outputs not zero: wr_en=%b busy=%b wr_addr=%h pixelA=%h op=%h",
               bus1.wr_en, busy1, bus1.wr_addr, bus1.pixelA, bus1.opcode);
    end
    tick();
    checks++;
    if (bus1.wr_en !== 1'b0 || busy2 !== 1'b0) begin
      errors++;
      $display("FAIL rst_hold got wr_en=%b busy2=%b want 0/0", bus1.wr_en, busy2);
    end
    rst = 1'b1;
    tick();
    set_cfg(4'h1, 8'h07, 16'd1, 16'h0040, 16'h0050, 16'h0060);
    start_run();
    for (int c = 1; c <= 5; c++) begin
      if (c == 4) begin
        checks++;
        if (bus1.wr_en !== 1'b1 || bus1.wr_addr !== 16'h0060 || bus1.wr_data !== 8'h83) begin
          errors++;
          $display("FAIL rst_rerun_wr got %b:%h:%h want 1:0060:83",
                   bus1.wr_en, bus1.wr_addr, bus1.wr_data);
        end
      end
      if (c == 5) begin
        checks++;
        if (done1 !== 1'b1) begin
          errors++;
          $display("FAIL rst_rerun_done got %b want 1", done1);
        end
      end
      tick();
    end
    settle();
  endtask

  task automatic test_restart_ignored();
    logic [7:0] exp_data [3];
    int bad_op = 0;
    exp_data[0] = 8'h83;
    exp_data[1] = 8'h81;
    exp_data[2] = 8'h83;
    set_cfg(4'h3, 8'h05, 16'd3, 16'h0010, 16'h0020, 16'h0030);
    start_run();
    for (int c = 1; c <= 13; c++) begin
      if (c == 2) begin
        set_cfg(4'hC, 8'h99, 16'd7, 16'h0080, 16'h0090, 16'h00A0);
        i_start = 1'b1;
      end
      if (c == 4) i_start = 1'b0;
      if (bus1.opcode !== 4'h3 || bus1.userInputA !== 8'h05) bad_op++;
      if (c == 4 || c == 8 || c == 12) begin
        checks++;
        if (bus1.wr_en !== 1'b1 || bus1.wr_addr !== 16'h0030 + 16'(c / 4 - 1) ||
            bus1.wr_data !== exp_data[c / 4 - 1]) begin
          errors++;
          $display("FAIL restart_wr c=%0d got %b:%h:%h", c, bus1.wr_en, bus1.wr_addr,
                   bus1.wr_data);
        end
      end
      if (c == 13) begin
        checks++;
        if (done1 !== 1'b1) begin
          errors++;
          $display("FAIL restart_done got %b want 1", done1);
        end
      end
      tick();
    end
    checks++;
    if (bad_op != 0) begin
      errors++;
      $display("FAIL restart_opcode_stable got %0d bad cycles want 0", bad_op);
    end
    settle();
  endtask

  initial begin
    rst     = 1'b0;
    i_start = 1'b0;
    i_abort = 1'b0;
    set_cfg(4'h0, 8'h00, 16'd0, 16'h0000, 16'h0000, 16'h0000);
    tick();
    tick();
    test_reset();
    rst = 1'b1;
    tick();
    // Abort while idle must not disturb anything.
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    test_basic();
    test_zero();
    test_wrap();
    test_abort();
    test_reset_mid_run();
    test_restart_ignored();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
